// File: rtl/tinyneuron_lif_core.sv
// Leaky integrate-and-fire neuron core.
// Each accepted input sample applies a shift-based leak, adds the signed input
// current and compares the saturated result to a programmable threshold.
// A crossing produces a one-cycle spike, clears the membrane, bumps a saturating
// spike counter and (optionally) enters a refractory period during which input
// samples are refused and dropped.
module tinyneuron_lif_core #(
  parameter int unsigned V_W   = 12,
  parameter int unsigned CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  input  logic                  cfg_we,
  input  logic [1:0]            cfg_addr,
  input  logic [7:0]            cfg_data,
  output logic                  spike,
  output logic signed [V_W-1:0] membrane,
  output logic [CNT_W-1:0]      spike_count,
  output logic                  refrac
);

  // Two guard bits are enough for membrane - leak + input without wrapping.
  localparam int unsigned SumW = V_W + 2;
  localparam int unsigned HiW  = V_W - 8;

  localparam logic signed [SumW-1:0] VMax   = {3'b000, {(V_W-1){1'b1}}};
  localparam logic signed [SumW-1:0] VMin   = {3'b111, {(V_W-1){1'b0}}};
  localparam logic signed [V_W-1:0]  ThrRst = V_W'(100);
  localparam logic [2:0]             LeakRst   = 3'd3;
  localparam logic [7:0]             RefracRst = 8'd4;

  typedef enum logic [0:0] {
    StActive,
    StRefrac
  } state_e;

  state_e                state_q, state_d;
  logic signed [V_W-1:0] membrane_q, membrane_d;
  logic                  spike_q, spike_d;
  logic [CNT_W-1:0]      spike_count_q, spike_count_d;
  logic [7:0]            rcnt_q, rcnt_d;
  logic signed [V_W-1:0] thr_q, thr_d;
  logic [2:0]            leak_shift_q, leak_shift_d;
  logic [7:0]            refrac_len_q, refrac_len_d;

  logic                  accept;
  logic                  fire;
  logic signed [SumW-1:0] mem_ext, leak, in_ext, sum;
  logic signed [V_W-1:0] v_next;
  logic [HiW-1:0]        cfg_hi;

  // Upper threshold bits come from the low bits of cfg_data; for very wide
  // membranes the byte is sign-extended so thr stays a signed quantity.
  if (HiW <= 8) begin : g_hi_narrow
    assign cfg_hi = cfg_data[HiW-1:0];
  end else begin : g_hi_wide
    assign cfg_hi = {{(HiW-8){cfg_data[7]}}, cfg_data};
  end

  assign in_ready    = (state_q == StActive);
  assign refrac      = (state_q == StRefrac);
  assign spike       = spike_q;
  assign membrane    = membrane_q;
  assign spike_count = spike_count_q;

  assign accept = in_valid && in_ready;

  // Leak + integrate datapath with saturation back to the membrane range.
  always_comb begin
    mem_ext = {{2{membrane_q[V_W-1]}}, membrane_q};
    in_ext  = {{(SumW-8){in_data[7]}}, in_data};
    leak    = '0;
    if (leak_shift_q != 3'd0) begin
      leak = mem_ext >>> leak_shift_q;
    end
    sum = mem_ext - leak + in_ext;
    if (sum > VMax) begin
      v_next = VMax[V_W-1:0];
    end else if (sum < VMin) begin
      v_next = VMin[V_W-1:0];
    end else begin
      v_next = sum[V_W-1:0];
    end
    fire = accept && (v_next >= thr_q);
  end

  // Configuration register writes; the datapath above always sees the old values.
  always_comb begin
    thr_d        = thr_q;
    leak_shift_d = leak_shift_q;
    refrac_len_d = refrac_len_q;
    if (cfg_we) begin
      case (cfg_addr)
        2'd0:    thr_d[7:0]     = cfg_data;
        2'd1:    thr_d[V_W-1:8] = cfg_hi;
        2'd2:    leak_shift_d   = cfg_data[2:0];
        default: refrac_len_d   = cfg_data;
      endcase
    end
  end

  // Neuron state machine: integrate/fire in active, count down in refractory.
  always_comb begin
    state_d       = state_q;
    membrane_d    = membrane_q;
    spike_d       = 1'b0;
    spike_count_d = spike_count_q;
    rcnt_d        = rcnt_q;
    unique case (state_q)
      StActive: begin
        if (accept) begin
          if (fire) begin
            membrane_d = '0;
            spike_d    = 1'b1;
            if (spike_count_q != {CNT_W{1'b1}}) begin
              spike_count_d = spike_count_q + 1'b1;
            end
            if (refrac_len_q != 8'd0) begin
              state_d = StRefrac;
              rcnt_d  = refrac_len_q;
            end
          end else begin
            membrane_d = v_next;
          end
        end
      end
      StRefrac: begin
        // rcnt is never 0 here; the <= guard only protects against upsets.
        rcnt_d = rcnt_q - 8'd1;
        if (rcnt_q <= 8'd1) begin
          state_d = StActive;
        end
      end
      default: state_d = StActive;
    endcase
  end

  // State and configuration registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StActive;
      membrane_q    <= '0;
      spike_q       <= 1'b0;
      spike_count_q <= '0;
      rcnt_q        <= '0;
      thr_q         <= ThrRst;
      leak_shift_q  <= LeakRst;
      refrac_len_q  <= RefracRst;
    end else begin
      state_q       <= state_d;
      membrane_q    <= membrane_d;
      spike_q       <= spike_d;
      spike_count_q <= spike_count_d;
      rcnt_q        <= rcnt_d;
      thr_q         <= thr_d;
      leak_shift_q  <= leak_shift_d;
      refrac_len_q  <= refrac_len_d;
    end
  end

endmodule
